// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared encodings for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } irq_state_e;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int SRC_TOP   = 0;
  localparam int SRC_CMPR0 = 1;
  localparam int SRC_CMPR1 = 2;

endpackage

// File: rtl/irq_edge_detect.sv
// rtl/irq_edge_detect.sv - per-source rising-edge detector, optional synchronizer under IRQ_CTRL_SYNC_EN
module irq_edge_detect #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  output logic [N_SRC-1:0] rise
);

  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_q;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  // two-flop synchronizer so asynchronous pins can be connected directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  // previous sample, so a level held high yields only one rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
    end else begin
      src_q <= src_s;
    end
  end

  assign rise = src_s & ~src_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller with priority select and ack/iret handshake
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [7:0] BASE  = 8'h10,
  parameter int         N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic [7:0]       address,
  input  logic [7:0]       din,
  input  logic             w_en,
  input  logic             r_en,
  output logic [7:0]       dout,
  output logic             irq,
  output logic [2:0]       vector,
  input  logic             ack,
  input  logic             iret
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] act;
  logic             ctrl_en;
  irq_state_e       state;
  irq_state_e       state_nxt;
  logic             irq_nxt;
  logic [2:0]       vector_nxt;
  logic [2:0]       winner;
  logic             req;
  logic             cur_valid;
  logic [7:0]       off;
  logic             hit;
  logic             wr;
  logic             rd;
  logic [1:0]       reg_sel;
  logic [7:0]       rdata;

  irq_edge_detect #(.N_SRC(N_SRC)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (src),
    .rise  (rise)
  );

  // window decode: the subtraction wraps addresses below BASE to large offsets
  always_comb begin
    off     = address - BASE;
    hit     = (off < 8'd4);
    wr      = w_en & hit;
    rd      = r_en & hit;
    reg_sel = off[1:0];
  end

  assign act       = pending & mask;
  assign req       = (|act) & ctrl_en;
  assign cur_valid = pending[vector] & mask[vector] & ctrl_en;

  // lowest set index of the enabled pending bits wins
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) winner = 3'(i);
    end
  end

  // read mux; STATUS reports the live state and vector
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PENDING: rdata[N_SRC-1:0] = pending;
      REG_MASK:    rdata[N_SRC-1:0] = mask;
      REG_CTRL:    rdata[0]         = ctrl_en;
      default:     rdata            = {state, 3'b000, vector};
    endcase
  end

  // handshake FSM and pending update; new edges are OR-ed last so they beat any clear
  always_comb begin
    state_nxt   = state;
    irq_nxt     = irq;
    vector_nxt  = vector;
    pending_nxt = pending;
    if (wr && reg_sel == REG_PENDING) begin
      pending_nxt = pending_nxt & ~din[N_SRC-1:0];
    end
    case (state)
      ST_IDLE: begin
        irq_nxt = 1'b0;
        if (req) begin
          state_nxt  = ST_REQ;
          irq_nxt    = 1'b1;
          vector_nxt = winner;
        end else begin
          vector_nxt = '0;
        end
      end
      ST_REQ: begin
        if (!cur_valid) begin
          state_nxt  = ST_IDLE;
          irq_nxt    = 1'b0;
          vector_nxt = '0;
        end else if (ack) begin
          state_nxt            = ST_SERVICE;
          irq_nxt              = 1'b0;
          pending_nxt[vector]  = 1'b0;
        end
      end
      ST_SERVICE: begin
        irq_nxt = 1'b0;
        if (iret) begin
          state_nxt  = ST_IDLE;
          vector_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        irq_nxt    = 1'b0;
        vector_nxt = '0;
      end
    endcase
    pending_nxt = pending_nxt | rise;
  end

  // state, outputs and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      irq     <= 1'b0;
      vector  <= '0;
      pending <= '0;
      mask    <= '0;
      ctrl_en <= 1'b0;
      dout    <= '0;
    end else begin
      state   <= state_nxt;
      irq     <= irq_nxt;
      vector  <= vector_nxt;
      pending <= pending_nxt;
      if (wr && reg_sel == REG_MASK) mask    <= din[N_SRC-1:0];
      if (wr && reg_sel == REG_CTRL) ctrl_en <= din[0];
      if (rd) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic [7:0] address;
  logic [7:0] din;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       irq;
  logic [2:0] vector;
  logic       ack;
  logic       iret;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl #(.BASE(BASE), .N_SRC(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .address (address),
    .din     (din),
    .w_en    (w_en),
    .r_en    (r_en),
    .dout    (dout),
    .irq     (irq),
    .vector  (vector),
    .ack     (ack),
    .iret    (iret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din     = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
  endtask

  task automatic bus_read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    address = a;
    r_en    = 1'b1;
    tick();
    r_en    = 1'b0;
    check(tag, dout, exp);
  endtask

  task automatic pulse_src(input logic [7:0] s);
    src = s;
    tick();
    src = '0;
  endtask

  task automatic do_ack;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_iret;
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; src = '0; address = '0; din = '0;
    w_en = 1'b0; r_en = 1'b0; ack = 1'b0; iret = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_vector", {5'b0, vector}, 8'h00);
    check("rst_dout", dout, 8'h00);
    bus_read_check("rst_mask", BASE + 8'd1, 8'h00);

    // basic request on cmpr0
    bus_write(BASE + 8'd1, 8'h02);
    bus_write(BASE + 8'd2, 8'h01);
    pulse_src(8'h01 << SRC_CMPR0);
    check("basic_irq_n", {7'b0, irq}, 8'h00);
    tick();
    check("basic_irq_n1", {7'b0, irq}, 8'h01);
    check("basic_vector", {5'b0, vector}, 8'h01);
    do_ack();
    check("basic_ack_irq", {7'b0, irq}, 8'h00);
    bus_read_check("basic_pending", BASE, 8'h00);
    bus_read_check("basic_status_svc", BASE + 8'd3, 8'h81);
    do_iret();
    bus_read_check("basic_status_idle", BASE + 8'd3, 8'h00);

    // priority: sources 5 and 2 together
    bus_write(BASE + 8'd1, 8'hFF);
    pulse_src(8'h24);
    tick();
    check("prio_irq", {7'b0, irq}, 8'h01);
    check("prio_vector", {5'b0, vector}, 8'h02);
    do_ack();
    bus_read_check("prio_pending", BASE, 8'h20);
    do_iret();
    check("prio_iret_irq", {7'b0, irq}, 8'h00);
    tick();
    check("prio_second_irq", {7'b0, irq}, 8'h01);
    check("prio_second_vec", {5'b0, vector}, 8'h05);
    do_ack();
    do_iret();

    // masked source, then enabled by a MASK write
    bus_write(BASE + 8'd1, 8'h00);
    pulse_src(8'h01 << SRC_TOP);
    tick();
    check("mask_irq_off", {7'b0, irq}, 8'h00);
    bus_read_check("mask_pending", BASE, 8'h01);
    bus_write(BASE + 8'd1, 8'h01);
    check("mask_irq_w", {7'b0, irq}, 8'h00);
    tick();
    check("mask_irq_w1", {7'b0, irq}, 8'h01);
    check("mask_vector", {5'b0, vector}, 8'h00);
    do_ack();
    do_iret();

    // withdrawal by W1C while in REQ; late ack ignored
    bus_write(BASE + 8'd1, 8'h08);
    pulse_src(8'h08);
    tick();
    check("wd_irq", {7'b0, irq}, 8'h01);
    check("wd_vector", {5'b0, vector}, 8'h03);
    bus_write(BASE, 8'h08);
    check("wd_irq_same", {7'b0, irq}, 8'h01);
    tick();
    check("wd_irq_drop", {7'b0, irq}, 8'h00);
    bus_read_check("wd_status", BASE + 8'd3, 8'h00);
    do_ack();
    check("wd_ack_irq", {7'b0, irq}, 8'h00);
    bus_read_check("wd_ack_status", BASE + 8'd3, 8'h00);

    // collision: set beats same-cycle W1C
    bus_write(BASE + 8'd1, 8'h00);
    src = 8'h10;
    bus_write(BASE, 8'h10);
    src = 8'h00;
    bus_read_check("coll_pending", BASE, 8'h10);
    bus_write(BASE, 8'h10);
    bus_read_check("w1c_pending", BASE, 8'h00);

    // level source: one set per 0->1 transition
    src = 8'h40;
    tick(); tick();
    bus_write(BASE, 8'h40);
    tick();
    bus_read_check("level_pending", BASE, 8'h00);
    src = 8'h00;

    // reset mid-ISR
    bus_write(BASE + 8'd1, 8'h04);
    pulse_src(8'h04);
    tick();
    check("rmid_irq", {7'b0, irq}, 8'h01);
    do_ack();
    pulse_src(8'h02);
    bus_read_check("rmid_status", BASE + 8'd3, 8'h82);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmid_irq0", {7'b0, irq}, 8'h00);
    check("rmid_vec0", {5'b0, vector}, 8'h00);
    check("rmid_dout0", dout, 8'h00);
    bus_read_check("rmid_pending", BASE, 8'h00);
    bus_read_check("rmid_mask", BASE + 8'd1, 8'h00);
    bus_read_check("rmid_ctrl", BASE + 8'd2, 8'h00);
    bus_read_check("rmid_status0", BASE + 8'd3, 8'h00);

    // address window
    bus_write(BASE + 8'd4, 8'hFF);
    bus_write(BASE - 8'd1, 8'hFF);
    bus_read_check("win_mask", BASE + 8'd1, 8'h00);
    bus_read_check("win_ctrl", BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd1, 8'h5A);
    bus_read_check("win_mask_rd", BASE + 8'd1, 8'h5A);
    bus_read_check("win_oob_hold", BASE + 8'd4, 8'h5A);
    bus_read_check("win_low_hold", BASE - 8'd1, 8'h5A);
    bus_write(BASE + 8'd2, 8'hFF);
    bus_read_check("win_ctrl_bit0", BASE + 8'd2, 8'h01);

    // stray ack and iret in IDLE
    do_ack();
    do_iret();
    check("stray_irq", {7'b0, irq}, 8'h00);
    bus_read_check("stray_status", BASE + 8'd3, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller directly downstream of the GPIO/counter-timer peripheral. It consumes that block's single-cycle interrupt flags (`top`, `cmpr0_interrupt`, `cmpr1_interrupt`) plus up to five other sources. It latches rising edges into pending bits, applies a mask, selects the highest-priority request and runs a request/acknowledge/return handshake with the CPU. It shares the CPU's 8-bit I/O bus (`address`/`din`/`dout`/`w_en`/`r_en`) with the I/O block and claims its own four-address window.

## Interface
- `BASE`, 8'h10: first address of the 4-register window.
- `N_SRC`, 8: number of interrupt sources, 1..8. Source 0 has the highest priority.
- `clk` input 1: system clock. All state updates on its rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `src` input N_SRC: interrupt sources. Bit 0 = timer `top`, bit 1 = `cmpr0_interrupt`, bit 2 = `cmpr1_interrupt`; the remaining bits are free.
- `address` input 8: I/O bus address.
- `din` input 8: write data.
- `w_en` input 1: write strobe.
- `r_en` input 1: read strobe.
- `dout` output 8: registered read data. Holds its value when not read.
- `irq` output 1: interrupt request to the CPU. Registered.
- `vector` output 3: index of the requested or active source. Registered.
- `ack` input 1: CPU accepts the request.
- `iret` input 1: CPU has finished the ISR.

## Operation
- **Register map** (offset from `BASE`):
  - 0 PENDING: R; write-1-to-clear.
  - 1 MASK: RW; 1 = enabled.
  - 2 CTRL: RW; bit0 is the global enable, other bits read 0.
  - 3 STATUS: R; `{state[1:0], 3'b0, vector}`.
- **Decode:** an access hits only when `address` is in `BASE`..`BASE+3`. Otherwise no register or `dout` change occurs.
- **Edge capture:** `src_q` holds the previous sample. `rise = src & ~src_q` sets the matching pending bits.
  - Set beats a same-cycle W1C of the same bit.
  - Set beats an `ack` clear of the same bit.
- **Request condition:** `req = |(pending & mask) & ctrl[0]`. Winner = lowest set index of `pending & mask`.
- **FSM:**
  - IDLE (2'b00): if `req`, latch the winner into `vector`, set `irq`=1 and go to REQ.
  - REQ (2'b01):
    - `ack` → clear `pending[vector]`, `irq`=0, go to SERVICE.
    - `req` deasserts, or `pending[vector] & mask[vector]` drops (masked, W1C, global disable) before `ack` → `irq`=0, return to IDLE.
    - `vector` does not change while in REQ, even if a higher-priority source becomes pending.
  - SERVICE (2'b10): `vector` holds the active source. `iret` → IDLE. New edges keep accumulating in PENDING. No nesting.
- **Ignored strobes:** `ack` outside REQ and `iret` outside SERVICE have no effect.
- **Same-cycle bus write and FSM evaluation:** the FSM sees register values from before the edge.

## Timing
- **Reset** (`rst_n`=0 at an edge): state IDLE; `irq`=0; `vector`=0; `dout`=0; PENDING, MASK, CTRL and `src_q` all 0. Reset mid-request or mid-ISR drops everything with no completion.
- **Source to pending:** `src` first sampled high at edge N → pending bit visible after edge N.
- **Request latency:** `irq`=1 after edge N+1, two cycles from the source edge, when masked-in and enabled.
- **Ack:** `ack` sampled at edge M → `irq`=0 and the pending bit cleared after edge M.
- **Return:** `iret` at edge M → IDLE. A still-pending request raises `irq` after edge M+1.
- **Read latency:** `dout` is valid one cycle after the `r_en` edge.
- **Level sources:** a source held high creates one pending set per 0→1 transition only.

## Configuration
- **`IRQ_CTRL_SYNC_EN` defined:** `src` passes through a two-flop synchronizer before edge detection. This makes asynchronous external pins safe and adds 2 cycles, so source-to-`irq` becomes 4 cycles.
- **Undefined:** `src` is assumed synchronous to `clk`, with no synchronizer and 2-cycle latency.

## Structure
- **Package `irq_pkg`:**
  - state encoding (IDLE=2'b00, REQ=2'b01, SERVICE=2'b10)
  - register offsets (PENDING=0, MASK=1, CTRL=2, STATUS=3)
  - the source index constants for the timer flags
- **Sub-module `irq_edge_detect`:** per-source `src_q`, the optional synchronizer and the `rise` output. The FSM, priority encoder and bus decode stay in `irq_ctrl`.

## Test plan
- **Basic request:** reset; write MASK=8'h02, CTRL=1; pulse `src[1]` for 1 cycle → `irq`=1 two cycles later with `vector`=1; `ack` → `irq`=0, PENDING reads 8'h00; `iret` → STATUS reads 8'h00.
- **Priority:** MASK=8'hFF; pulse `src[5]` and `src[2]` in the same cycle → `vector`=2. After `ack`+`iret`, `vector`=5 and `irq`=1 one cycle after `iret`.
- **Masked source:** MASK=8'h00; pulse `src[0]` → PENDING=8'h01 and `irq` stays 0. Write MASK=8'h01 → `irq`=1 two cycles after the write edge.
- **Withdrawal:** in REQ with `vector`=3, write PENDING=8'h08 (W1C) → `irq`=0 and state IDLE next cycle. A later `ack` is ignored.
- **Collision:** W1C of bit 4 in the same cycle as a `src[4]` rising edge → PENDING bit 4 stays 1.
- **Reset mid-operation and address window:** reset asserted in SERVICE → all outputs and registers 0. A write to `BASE+4` changes nothing. A read of `BASE+1` returns MASK one cycle later.
